memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single memory request/response channel.
// Optional response watchdog: define MEMORY_BUS_ARBITER_TIMEOUT_EN.
module memory_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 64,
    parameter int SRC_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           rq_busy,
    input  logic [1:0]           rq_type0,
    input  logic [1:0]           rq_type1,
    input  logic [SRC_W-1:0]     rq_src0,
    input  logic [SRC_W-1:0]     rq_src1,
    input  logic [ADDR_W-1:0]    rq_addr0,
    input  logic [ADDR_W-1:0]    rq_addr1,
    input  logic [PAYLOAD_W-1:0] rq_payload0,
    input  logic [PAYLOAD_W-1:0] rq_payload1,
    output logic [1:0]           rq_take,
    output logic                 mem_req_busy,
    output logic [1:0]           mem_req_type,
    output logic [SRC_W-1:0]     mem_req_src,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [PAYLOAD_W-1:0] mem_req_payload,
    input  logic                 mem_req_taken,
    input  logic                 mem_rsp_busy,
    input  logic [PAYLOAD_W-1:0] mem_rsp_payload,
    output logic                 mem_rsp_take,
    output logic [1:0]           rsp_busy,
    output logic [PAYLOAD_W-1:0] rsp_payload,
    input  logic [1:0]           rsp_take,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } state_e;

    localparam logic [1:0] TYPE_READ_DATA = 2'd0;

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 win_s;
    logic [1:0]           rq_take_q, rq_take_d;
    logic                 mem_req_busy_q, mem_req_busy_d;
    logic [1:0]           mem_req_type_q, mem_req_type_d;
    logic [SRC_W-1:0]     mem_req_src_q, mem_req_src_d;
    logic [ADDR_W-1:0]    mem_req_addr_q, mem_req_addr_d;
    logic [PAYLOAD_W-1:0] mem_req_payload_q, mem_req_payload_d;
    logic                 mem_rsp_take_q, mem_rsp_take_d;
    logic [1:0]           rsp_busy_q, rsp_busy_d;
    logic [PAYLOAD_W-1:0] rsp_payload_q, rsp_payload_d;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
`endif

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        if (rq_busy == 2'b11) begin
            win_s = ~grant_q;
        end else if (rq_busy[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rq_take_d         = 2'b00;
        mem_req_busy_d    = mem_req_busy_q;
        mem_req_type_d    = mem_req_type_q;
        mem_req_src_d     = mem_req_src_q;
        mem_req_addr_d    = mem_req_addr_q;
        mem_req_payload_d = mem_req_payload_q;
        mem_rsp_take_d    = 1'b0;
        rsp_busy_d        = rsp_busy_q;
        rsp_payload_d     = rsp_payload_q;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
        wait_cnt_d        = wait_cnt_q;
        timeout_err_d     = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (rq_busy != 2'b00) begin
                    grant_d        = win_s;
                    rq_take_d      = win_s ? 2'b10 : 2'b01;
                    mem_req_busy_d = 1'b1;
                    state_d        = ISSUE;
                    if (win_s) begin
                        mem_req_type_d    = rq_type1;
                        mem_req_src_d     = rq_src1;
                        mem_req_addr_d    = rq_addr1;
                        mem_req_payload_d = rq_payload1;
                    end else begin
                        mem_req_type_d    = rq_type0;
                        mem_req_src_d     = rq_src0;
                        mem_req_addr_d    = rq_addr0;
                        mem_req_payload_d = rq_payload0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_req_taken) begin
                    mem_req_busy_d = 1'b0;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
                    wait_cnt_d     = 8'd0;
`endif
                    if (mem_req_type_q == TYPE_READ_DATA) begin
                        state_d = WAIT_RSP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_busy) begin
                    mem_rsp_take_d = 1'b1;
                    rsp_payload_d  = mem_rsp_payload;
                    rsp_busy_d     = grant_q ? 2'b10 : 2'b01;
                    state_d        = DELIVER;
                end else begin
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
                    // 255th silent cycle abandons the read without a response.
                    if (wait_cnt_q == 8'd254) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
`else
                    state_d = WAIT_RSP;
`endif
                end
            end
            DELIVER: begin
                if (rsp_take[grant_q]) begin
                    rsp_busy_d = 2'b00;
                    state_d    = IDLE;
                end else begin
                    state_d = DELIVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; last-grant resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            grant_q           <= 1'b1;
            rq_take_q         <= 2'b00;
            mem_req_busy_q    <= 1'b0;
            mem_req_type_q    <= 2'd0;
            mem_req_src_q     <= '0;
            mem_req_addr_q    <= '0;
            mem_req_payload_q <= '0;
            mem_rsp_take_q    <= 1'b0;
            rsp_busy_q        <= 2'b00;
            rsp_payload_q     <= '0;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
            wait_cnt_q        <= 8'd0;
            timeout_err_q     <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            grant_q           <= grant_d;
            rq_take_q         <= rq_take_d;
            mem_req_busy_q    <= mem_req_busy_d;
            mem_req_type_q    <= mem_req_type_d;
            mem_req_src_q     <= mem_req_src_d;
            mem_req_addr_q    <= mem_req_addr_d;
            mem_req_payload_q <= mem_req_payload_d;
            mem_rsp_take_q    <= mem_rsp_take_d;
            rsp_busy_q        <= rsp_busy_d;
            rsp_payload_q     <= rsp_payload_d;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
            wait_cnt_q        <= wait_cnt_d;
            timeout_err_q     <= timeout_err_d;
`endif
        end
    end

    assign rq_take         = rq_take_q;
    assign mem_req_busy    = mem_req_busy_q;
    assign mem_req_type    = mem_req_type_q;
    assign mem_req_src     = mem_req_src_q;
    assign mem_req_addr    = mem_req_addr_q;
    assign mem_req_payload = mem_req_payload_q;
    assign mem_rsp_take    = mem_rsp_take_q;
    assign rsp_busy        = rsp_busy_q;
    assign rsp_payload     = rsp_payload_q;
`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
    assign timeout_err     = timeout_err_q;
`else
    assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the arbitration and response routing rules.
module tb_memory_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rq_busy = 2'b00;
    logic [1:0]  rq_type0 = 2'd0, rq_type1 = 2'd0;
    logic [3:0]  rq_src0 = 4'd0, rq_src1 = 4'd0;
    logic [31:0] rq_addr0 = 32'd0, rq_addr1 = 32'd0;
    logic [63:0] rq_payload0 = 64'd0, rq_payload1 = 64'd0;
    logic [1:0]  rq_take;
    logic        mem_req_busy;
    logic [1:0]  mem_req_type;
    logic [3:0]  mem_req_src;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_payload;
    logic        mem_req_taken = 1'b0;
    logic        mem_rsp_busy = 1'b0;
    logic [63:0] mem_rsp_payload = 64'd0;
    logic        mem_rsp_take;
    logic [1:0]  rsp_busy;
    logic [63:0] rsp_payload;
    logic [1:0]  rsp_take = 2'b00;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int last_grant = 1;

    memory_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n), .rq_busy(rq_busy),
        .rq_type0(rq_type0), .rq_type1(rq_type1), .rq_src0(rq_src0), .rq_src1(rq_src1),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_payload0(rq_payload0), .rq_payload1(rq_payload1), .rq_take(rq_take),
        .mem_req_busy(mem_req_busy), .mem_req_type(mem_req_type), .mem_req_src(mem_req_src),
        .mem_req_addr(mem_req_addr), .mem_req_payload(mem_req_payload),
        .mem_req_taken(mem_req_taken), .mem_rsp_busy(mem_rsp_busy),
        .mem_rsp_payload(mem_rsp_payload), .mem_rsp_take(mem_rsp_take),
        .rsp_busy(rsp_busy), .rsp_payload(rsp_payload), .rsp_take(rsp_take),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("rq_take_onehot0", {63'd0, $onehot0(rq_take)}, 64'd1);
        check("rsp_busy_onehot0", {63'd0, $onehot0(rsp_busy)}, 64'd1);
    endtask

    // Round-robin rule: a lone requester wins; on a tie the port not granted last wins.
    function automatic int model_winner(input logic [1:0] b, input int last);
        if (b == 2'b11) return 1 - last;
        return b[1] ? 1 : 0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rq_busy = 2'b00; mem_req_taken = 1'b0; mem_rsp_busy = 1'b0; rsp_take = 2'b00;
        #1;
        check("rst_mem_req_busy", mem_req_busy, 64'd0);
        check("rst_rq_take", rq_take, 64'd0);
        check("rst_mem_rsp_take", mem_rsp_take, 64'd0);
        check("rst_rsp_busy", rsp_busy, 64'd0);
        check("rst_timeout_err", timeout_err, 64'd0);
        check("rst_mem_req_addr", mem_req_addr, 64'd0);
        check("rst_mem_req_payload", mem_req_payload, 64'd0);
        check("rst_mem_req_src", mem_req_src, 64'd0);
        check("rst_rsp_payload", rsp_payload, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        last_grant = 1;
    endtask

    // One complete transaction starting in IDLE with the requesters already driven.
    task automatic run_txn(input int taken_dly, input int rsp_dly, input logic [63:0] rsp_val,
                           input int wrong_cycles);
        int g;
        logic [1:0]  e_type, g_mask;
        logic [3:0]  e_src;
        logic [31:0] e_addr;
        logic [63:0] e_pay;
        g      = model_winner(rq_busy, last_grant);
        g_mask = (g == 0) ? 2'b01 : 2'b10;
        e_type = (g == 0) ? rq_type0 : rq_type1;
        e_src  = (g == 0) ? rq_src0 : rq_src1;
        e_addr = (g == 0) ? rq_addr0 : rq_addr1;
        e_pay  = (g == 0) ? rq_payload0 : rq_payload1;
        step();
        check("grant_rq_take", rq_take, g_mask);
        check("grant_req_busy", mem_req_busy, 64'd1);
        check("grant_req_type", mem_req_type, e_type);
        check("grant_req_src", mem_req_src, e_src);
        check("grant_req_addr", mem_req_addr, e_addr);
        check("grant_req_payload", mem_req_payload, e_pay);
        rq_busy[g] = 1'b0;
        rq_payload0 = ~rq_payload0;
        rq_payload1 = ~rq_payload1;
        last_grant = g;
        for (int i = 0; i < taken_dly; i++) begin
            step();
            check("issue_rq_take_pulse", rq_take, 64'd0);
            check("issue_req_busy", mem_req_busy, 64'd1);
            check("issue_req_addr_stable", mem_req_addr, e_addr);
            check("issue_req_payload_stable", mem_req_payload, e_pay);
        end
        mem_req_taken = 1'b1;
        step();
        mem_req_taken = 1'b0;
        check("taken_req_busy", mem_req_busy, 64'd0);
        check("taken_rq_take", rq_take, 64'd0);
        if (e_type == 2'd0) begin
            for (int i = 0; i < rsp_dly; i++) begin
                step();
                check("wait_mem_rsp_take", mem_rsp_take, 64'd0);
                check("wait_rsp_busy", rsp_busy, 64'd0);
            end
            mem_rsp_busy = 1'b1;
            mem_rsp_payload = rsp_val;
            step();
            mem_rsp_busy = 1'b0;
            mem_rsp_payload = ~rsp_val;
            check("rsp_mem_rsp_take", mem_rsp_take, 64'd1);
            check("rsp_busy_port", rsp_busy, g_mask);
            check("rsp_payload", rsp_payload, rsp_val);
            for (int i = 0; i < wrong_cycles; i++) begin
                rsp_take = ~g_mask;
                step();
                check("deliver_wrong_take_ignored", rsp_busy, g_mask);
                check("deliver_mem_rsp_take_once", mem_rsp_take, 64'd0);
            end
            rsp_take = g_mask;
            step();
            rsp_take = 2'b00;
            check("deliver_cleared", rsp_busy, 64'd0);
            check("deliver_payload_hold", rsp_payload, rsp_val);
        end else begin
            check("write_no_rsp_busy", rsp_busy, 64'd0);
        end
    endtask

    initial begin
        int n;
        apply_reset();

        // Single read from port 0: taken after 2 cycles, response after 3.
        rq_type0 = 2'd0; rq_src0 = 4'd1; rq_addr0 = 32'h100; rq_payload0 = 64'h0;
        rq_busy = 2'b01;
        run_txn(2, 3, 64'hDEAD, 1);

        // Contention straight after reset: port 0 then port 1, back-to-back writes.
        apply_reset();
        rq_type0 = 2'd1; rq_src0 = 4'd2; rq_addr0 = 32'h10; rq_payload0 = 64'h1111;
        rq_type1 = 2'd1; rq_src1 = 4'd3; rq_addr1 = 32'h20; rq_payload1 = 64'h2222;
        rq_busy = 2'b11;
        run_txn(0, 0, 64'd0, 0);
        run_txn(0, 0, 64'd0, 0);

        // Port 1 write with no response; stray mem_rsp_busy in IDLE is ignored.
        rq_type1 = 2'd1; rq_src1 = 4'd4; rq_addr1 = 32'h40; rq_payload1 = 64'h55;
        rq_busy = 2'b10;
        run_txn(1, 0, 64'd0, 0);
        mem_rsp_busy = 1'b1; mem_rsp_payload = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_stray_rsp_take", mem_rsp_take, 64'd0);
            check("idle_stray_rsp_busy", rsp_busy, 64'd0);
        end
        mem_rsp_busy = 1'b0;
        rq_type0 = 2'd2; rq_src0 = 4'd5; rq_addr0 = 32'h44; rq_payload0 = 64'h66;
        rq_busy = 2'b01;
        run_txn(0, 0, 64'd0, 0);

        // Reset while waiting for a read response.
        rq_type0 = 2'd0; rq_src0 = 4'd6; rq_addr0 = 32'h200; rq_payload0 = 64'h77;
        rq_busy = 2'b01;
        step();
        check("midrst_grant", rq_take, 64'd1);
        rq_busy = 2'b00;
        mem_req_taken = 1'b1;
        step();
        mem_req_taken = 1'b0;
        apply_reset();
        mem_rsp_busy = 1'b1; mem_rsp_payload = 64'hBAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stale_rsp_take", mem_rsp_take, 64'd0);
            check("stale_rsp_busy", rsp_busy, 64'd0);
            check("stale_req_busy", mem_req_busy, 64'd0);
        end
        mem_rsp_busy = 1'b0;

`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
        rq_type0 = 2'd0; rq_addr0 = 32'h300; rq_busy = 2'b01;
        step();
        check("to_grant", rq_take, 64'd1);
        rq_busy = 2'b00;
        last_grant = 0;
        mem_req_taken = 1'b1;
        step();
        mem_req_taken = 1'b0;
        n = 0;
        while (timeout_err !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("to_cycles", n, 64'd255);
        check("to_err", timeout_err, 64'd1);
        check("to_rsp_busy", rsp_busy, 64'd0);
        rq_type1 = 2'd1; rq_addr1 = 32'h304; rq_busy = 2'b10;
        run_txn(0, 0, 64'd0, 0);
        check("to_err_sticky", timeout_err, 64'd1);
`else
        rq_type0 = 2'd0; rq_addr0 = 32'h300; rq_busy = 2'b01;
        run_txn(0, 300, 64'hBEEF, 0);
        check("no_timeout_err", timeout_err, 64'd0);
`endif

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            rq_type0 = 2'($urandom_range(0, 2)); rq_type1 = 2'($urandom_range(0, 2));
            rq_src0 = 4'($urandom); rq_src1 = 4'($urandom);
            rq_addr0 = $urandom; rq_addr1 = $urandom;
            rq_payload0 = {$urandom, $urandom}; rq_payload1 = {$urandom, $urandom};
            rq_busy = 2'($urandom_range(1, 3));
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
